reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 12 +
 rtl/rf_word.sv | 39 +++
 rtl/reg_file.sv | 137 +++++++++++++
 tb/tb_reg_file.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the reg_file register array and its clear sequencer.
package reg_file_pkg;

    localparam int RF_WIDTH_DEF = 32;
    localparam int RF_DEPTH_DEF = 32;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_word.sv
// One register-file entry: per-byte write enable, synchronous clear, async reset.
module rf_word #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH/8-1:0] be,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               clr,
    output logic [WIDTH-1:0]   q
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] word_d;
    logic [WIDTH-1:0] word_q;

    always_comb begin
        // NOTE: word_d takes its held value first, so bytes left unassigned below cannot infer a latch.
        word_d = word_q;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) word_d[8*b +: 8] = wr_data[8*b +: 8];
        end
        if (clr) word_d = '0;
    end

    // NOTE: this storage is reset on purpose. Reset must zero every entry, so the array is built from flops and not from a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            // NOTE: use non-blocking assignment so every entry updates from values sampled before the clock edge.
            word_q <= word_d;
        end
    end

    assign q = word_q;

endmodule

// File: rtl/reg_file.sv
// Two-read/one-write register file with byte enables and a sequential clear engine.
// Define RF_BYPASS_EN to forward a same-cycle write to the read ports. Without it, a same-cycle read returns the old contents.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH   = RF_WIDTH_DEF,
    parameter int DEPTH   = RF_DEPTH_DEF,
    parameter int ZERO_R0 = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [WIDTH/8-1:0]       wr_be,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_a,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_b,
    output logic [WIDTH-1:0]         rd_data_a,
    output logic [WIDTH-1:0]         rd_data_b,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     clr_done,
    output logic                     wr_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem [DEPTH];

    rf_state_e        state_q, state_d;
    logic [AW-1:0]    clr_idx_q, clr_idx_d;
    logic             clr_done_q, clr_done_d;
    logic             wr_drop_q, wr_drop_d;
    logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
    logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
    logic             busy_w;
    logic             wr_accept;

    assign busy_w    = (state_q == RF_CLEAR);
    // Writes to a hard-wired zero entry are swallowed silently rather than dropped.
    assign wr_accept = wr_en && !busy_w && !((ZERO_R0 != 0) && (wr_addr == '0));
    assign wr_drop_d = wr_en && busy_w;

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        if ((ZERO_R0 != 0) && (i == 0)) begin : g_zero
            assign mem[i] = '0;
        end else begin : g_ff
            logic [NB-1:0] be;
            logic          clr;

            assign be  = (wr_accept && (wr_addr == AW'(i))) ? wr_be : '0;
            assign clr = busy_w && (clr_idx_q == AW'(i));

            rf_word #(.WIDTH(WIDTH)) u_word (
                .clk     (clk),
                .rst_n   (rst_n),
                .be      (be),
                .wr_data (wr_data),
                .clr     (clr),
                .q       (mem[i])
            );
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        clr_done_d = 1'b0;
        case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d   = RF_CLEAR;
                    clr_idx_d = '0;
                end
            end
            RF_CLEAR: begin
                if (clr_idx_q == AW'(DEPTH - 1)) begin
                    state_d    = RF_IDLE;
                    clr_done_d = 1'b1;
                    clr_idx_d  = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            default: state_d = RF_IDLE;
        endcase
    end

`ifdef RF_BYPASS_EN
    logic [WIDTH-1:0] wr_merged;

    always_comb begin
        wr_merged = mem[wr_addr];
        for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) wr_merged[8*b +: 8] = wr_data[8*b +: 8];
        end
    end

    always_comb begin
        rd_data_a_d = mem[rd_addr_a];
        rd_data_b_d = mem[rd_addr_b];
        if (wr_accept && (rd_addr_a == wr_addr)) rd_data_a_d = wr_merged;
        if (wr_accept && (rd_addr_b == wr_addr)) rd_data_b_d = wr_merged;
    end
`else
    always_comb begin
        rd_data_a_d = mem[rd_addr_a];
        rd_data_b_d = mem[rd_addr_b];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RF_IDLE;
            clr_idx_q   <= '0;
            clr_done_q  <= 1'b0;
            wr_drop_q   <= 1'b0;
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            clr_done_q  <= clr_done_d;
            wr_drop_q   <= wr_drop_d;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
        end
    end

    assign busy      = busy_w;
    assign clr_done  = clr_done_q;
    assign wr_drop   = wr_drop_q;
    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file with default parameters. It covers byte writes, zero entry 0, the clear sequence and reset abort.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        clr_req;
    logic        busy;
    logic        clr_done;
    logic        wr_drop;

    int tests;
    int fails;
    int busy_cnt;
    int done_cnt;
    int done_k;
    int nz;
    logic [31:0] exp_byp;

    reg_file #(.WIDTH(32), .DEPTH(32), .ZERO_R0(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .clr_req   (clr_req),
        .busy      (busy),
        .clr_done  (clr_done),
        .wr_drop   (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return {8'(i), ~8'(i), 8'hA5, 8'h5A};
    endfunction

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; wr_be = 0;
        rd_addr_a = 0; rd_addr_b = 0; clr_req = 0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_rd_a", rd_data_a, 32'h0);
        check("rst_rd_b", rd_data_b, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_done", {31'd0, clr_done}, 32'h0);
        check("rst_drop", {31'd0, wr_drop}, 32'h0);
        tick(); tick();
        rst_n = 1'b1;

        // Test 1: full-word write and 1-cycle read latency
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
        tick();
        wr_en = 0; rd_addr_a = 5;
        tick();
        check("t1_full_write", rd_data_a, 32'hDEADBEEF);

        // Test 2: partial byte write
        wr_en = 1; wr_addr = 5; wr_data = 32'h11223344; wr_be = 4'h5;
        tick();
        wr_en = 0; rd_addr_a = 5; rd_addr_b = 5;
        tick();
        check("t2_byte_merge_a", rd_data_a, 32'hDE22BE44);
        check("t2_byte_merge_b", rd_data_b, 32'hDE22BE44);

        // wr_be=0 must not modify the entry
        wr_en = 1; wr_addr = 9; wr_data = 32'hFFFFFFFF; wr_be = 4'h0;
        tick();
        wr_en = 0; rd_addr_b = 9;
        tick();
        check("be0_noop", rd_data_b, 32'h0);

        // Test 3: read of the address being written in the same cycle
`ifdef RF_BYPASS_EN
        exp_byp = 32'hCAFEF00D;
`else
        exp_byp = 32'h0;
`endif
        wr_en = 1; wr_addr = 7; wr_data = 32'hCAFEF00D; wr_be = 4'hF; rd_addr_a = 7;
        tick();
        wr_en = 0;
        check("t3_same_cycle", rd_data_a, exp_byp);
        tick();
        check("t3_after", rd_data_a, 32'hCAFEF00D);

        // Test 4: entry 0 is hard-wired zero
        wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; wr_be = 4'hF; rd_addr_a = 0; rd_addr_b = 0;
        tick();
        wr_en = 0;
        check("t4_no_drop", {31'd0, wr_drop}, 32'h0);
        check("t4_r0_a_same", rd_data_a, 32'h0);
        tick();
        check("t4_r0_a", rd_data_a, 32'h0);
        check("t4_r0_b", rd_data_b, 32'h0);

        // Test 5: fill all entries, then run a full clear
        for (int i = 0; i < 32; i++) begin
            wr_en = 1; wr_addr = 5'(i); wr_data = pat(i); wr_be = 4'hF;
            tick();
        end
        wr_en = 0; rd_addr_a = 31; rd_addr_b = 1;
        tick();
        check("t5_fill_31", rd_data_a, pat(31));
        check("t5_fill_1", rd_data_b, pat(1));

        clr_req = 1;
        tick();
        clr_req = 0;
        busy_cnt = 0; done_cnt = 0; done_k = 0;
        for (int k = 1; k <= 40; k++) begin
            if (busy) busy_cnt++;
            if (clr_done) begin
                done_cnt++;
                done_k = k;
            end
            if (k == 6) begin
                check("t5_rd_cleared", rd_data_a, 32'h0);
                check("t5_rd_old", rd_data_b, pat(20));
            end
            if (k == 5) begin
                rd_addr_a = 2; rd_addr_b = 20;
            end
            clr_req = (k == 10);
            tick();
        end
        clr_req = 0;
        check("t5_busy_cycles", 32'(busy_cnt), 32'd32);
        check("t5_done_cycle", 32'(done_k), 32'd33);
        check("t5_done_count", 32'(done_cnt), 32'd1);

        nz = 0;
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
            tick();
            if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) nz++;
        end
        check("t5_all_zero", 32'(nz), 32'd0);

        // Test 6: write dropped while busy, then reset mid-clear
        wr_en = 1; wr_addr = 30; wr_data = 32'h13579BDF; wr_be = 4'hF;
        tick();
        wr_en = 0; clr_req = 1;
        tick();
        clr_req = 0;
        wr_en = 1; wr_addr = 30; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
        tick();
        check("t6_drop_pulse", {31'd0, wr_drop}, 32'h1);
        wr_en = 0; rd_addr_a = 30;
        tick();
        check("t6_drop_single", {31'd0, wr_drop}, 32'h0);
        check("t6_entry_kept", rd_data_a, 32'h13579BDF);
        repeat (9) tick();
        check("t6_busy_pre_rst", {31'd0, busy}, 32'h1);
        rst_n = 0;
        #1;
        check("t6_rst_busy", {31'd0, busy}, 32'h0);
        check("t6_rst_rd_a", rd_data_a, 32'h0);
        check("t6_rst_done", {31'd0, clr_done}, 32'h0);
        tick();
        wr_en = 1; wr_addr = 3; wr_data = 32'h0BADF00D; wr_be = 4'hF;
        rd_addr_a = 3; rd_addr_b = 30;
        rst_n = 1;
        tick();
        wr_en = 0;
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_cnt++;
            if (clr_done) done_cnt++;
            tick();
        end
        check("t6_no_busy", 32'(busy_cnt), 32'd0);
        check("t6_no_done", 32'(done_cnt), 32'd0);
        check("t6_first_write", rd_data_a, 32'h0BADF00D);
        check("t6_rst_cleared", rd_data_b, 32'h0);

        // Write and clr_req in the same idle cycle: the write lands, then the clear overwrites it
        wr_en = 1; wr_addr = 31; wr_data = 32'h00000077; wr_be = 4'hF; clr_req = 1; rd_addr_a = 31;
        tick();
        wr_en = 0; clr_req = 0;
        check("t7_busy", {31'd0, busy}, 32'h1);
        tick();
        check("t7_write_first", rd_data_a, 32'h00000077);
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (clr_done) done_cnt++;
            tick();
        end
        check("t7_done_seen", 32'(done_cnt), 32'd1);
        check("t7_overwritten", rd_data_a, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
